mem_stage: RTL
==============

# mem_stage

Memory-access pipeline stage between the execute stage and the write-back stage. It takes one instruction per handshake from execute, waits for the data SRAM read response on loads, and aligns and extends the returned data. It then hands {gr_we, dest, result, pc} to write-back and returns a forwarding/stall bus to decode. Variable SRAM latency is tolerated, and a response that arrives while write-back stalls is held in a one-entry buffer.

## Interface
- No parameters. Bus widths come from mycpu.h: ES_TO_MS_BUS_WD=74, MS_TO_WS_BUS_WD=70, MS_TO_DS_BUS_WD=39.
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-high
- ws_allowin  in  1  write-back can accept this cycle
- ms_allowin  out  1  this stage can accept from execute
- es_to_ms_valid  in  1  execute offers an instruction
- es_to_ms_bus  in  74  {load_op[73:71], res_from_mem[70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}
- ms_to_ws_valid  out  1  instruction complete and offered to write-back
- ms_to_ws_bus  out  70  {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}
- ms_to_ds_bus  out  39  {fwd_we[38], load_pending[37], dest[36:32], result[31:0]}
- data_sram_data_ok  in  1  read data valid this cycle (one pulse per load request)
- data_sram_rdata  in  32  read data

## Operation
- Registers:
  - ms_valid
  - ms_bus_r (74 bits)
  - rdata_buf (32 bits)
  - buf_valid
- load_op encoding: 000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu. Other codes are treated as lw.
- Pipeline handshake:
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - When ms_allowin is high: ms_valid <= es_to_ms_valid.
  - When es_to_ms_valid && ms_allowin: ms_bus_r <= es_to_ms_bus.
- Readiness:
  - resp = buf_valid || data_sram_data_ok.
  - ms_ready_go = !res_from_mem || resp.
  - ms_to_ws_valid = ms_valid && ms_ready_go.
- Response buffer:
  - Captures data_sram_rdata and sets buf_valid when data_sram_data_ok && ms_valid && res_from_mem && !buf_valid && !ws_allowin.
  - buf_valid clears on the cycle the instruction leaves (ms_to_ws_valid && ws_allowin).
  - When buf_valid is set, the buffer data is used and data_sram_rdata is ignored.
- Ignored responses: data_sram_data_ok is ignored when ms_valid=0 or when res_from_mem=0.
- Load data: mem_word = buf_valid ? rdata_buf : data_sram_rdata; a = alu_result[1:0].
  - lb/lbu: byte = mem_word[8a+7:8a]; lb sign-extends, lbu zero-extends.
  - lh/lhu: half = a[1] ? mem_word[31:16] : mem_word[15:0]; lh sign-extends, lhu zero-extends. a[0] is ignored.
  - lw: mem_word unchanged.
- final_result = res_from_mem ? load_data : alu_result.
- Forwarding bus to decode:
  - fwd_we = ms_valid && gr_we.
  - load_pending = ms_valid && res_from_mem && !resp. Decode must stall on a dest match while load_pending=1.
  - result = final_result.

## Timing
- Reset values (asynchronous): ms_valid=0 and buf_valid=0. This gives ms_allowin=1, ms_to_ws_valid=0, fwd_we=0 and load_pending=0. ms_bus_r and rdata_buf are not reset.
- Non-load instructions: zero added latency. Valid in the cycle after acceptance; leave at the next edge if ws_allowin=1.
- Loads with data_ok in the first resident cycle: same as non-loads; the result is combinational from data_sram_rdata.
- Loads with data_ok k cycles after entry: ms_to_ws_valid rises in the data_ok cycle. ms_allowin stays 0 until then if a new instruction is waiting.
- data_ok while ws_allowin=0: the data goes to rdata_buf. ms_to_ws_valid stays 1 from the data_ok cycle onward, with stable final_result, until ws_allowin=1.
- Back-to-back loads: the buffer clears and the next instruction is accepted at the same edge. The new load can never see the old buffer.
- Asynchronous reset mid-load: the instruction is discarded. A late data_ok after reset is ignored because ms_valid=0.

## Test plan
- ADD path: bus with res_from_mem=0, gr_we=1, dest=5, alu_result=0x12345678, pc=0xBFC00000, ws_allowin=1 -> the next cycle gives ms_to_ws_valid=1 and ms_to_ws_bus={1,5,0x12345678,0xBFC00000}; fwd_we=1 and load_pending=0.
- lb/lbu/lh/lhu with rdata=0x80FF7F01 and data_ok immediate:
  - lb with a=3 -> 0xFFFFFF80
  - lbu with a=3 -> 0x00000080
  - lh with a=2 -> 0xFFFF80FF
  - lhu with a=0 -> 0x00007F01
  - lw -> 0x80FF7F01
- Delayed response: lw with data_ok 3 cycles after entry -> load_pending=1 and ms_to_ws_valid=0 for 3 cycles, ms_allowin=0 with a younger instruction waiting, then valid in the data_ok cycle.
- Write-back stall: data_ok with rdata=0xDEADBEEF while ws_allowin=0 for 4 cycles, with rdata changing to 0 afterward -> final_result holds 0xDEADBEEF until handoff, then buf_valid=0.
- Reset: assert reset asynchronously mid-load, then pulse data_ok after release -> ms_valid=0 and ms_to_ws_valid=0 throughout, and no spurious handoff.

Source files
------------

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Memory-access stage. Waits for the SRAM load response, then aligns
//            and extends the data before handing the instruction to write-back.
// Revision : 1.0
// ============================================================================
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_allowin,
  output logic        ms_allowin,
  input  logic        es_to_ms_valid,
  input  logic [73:0] es_to_ms_bus,
  output logic        ms_to_ws_valid,
  output logic [69:0] ms_to_ws_bus,
  output logic [38:0] ms_to_ds_bus,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata
);
  localparam int ES_TO_MS_BUS_WD = 74;

  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;

  logic                       ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] ms_bus_r;
  logic [31:0]                rdata_buf;
  logic                       buf_valid;

  logic [2:0]  load_op;
  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] pc;

  logic        resp;
  logic        ms_ready_go;
  logic        buf_capture;
  logic [31:0] mem_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] final_result;

  assign {load_op, res_from_mem, gr_we, dest, alu_result, pc} = ms_bus_r;

  assign resp           = buf_valid || data_sram_data_ok;
  assign ms_ready_go    = !res_from_mem || resp;
  assign ms_to_ws_valid = ms_valid && ms_ready_go;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);

  // Only a response that cannot be consumed this cycle needs to be parked.
  assign buf_capture = data_sram_data_ok && ms_valid && res_from_mem
                       && !buf_valid && !ws_allowin;

  assign mem_word = buf_valid ? rdata_buf : data_sram_rdata;

  always_comb begin
    byte_sel = mem_word[7:0];
    case (alu_result[1:0])
      2'd1:    byte_sel = mem_word[15:8];
      2'd2:    byte_sel = mem_word[23:16];
      2'd3:    byte_sel = mem_word[31:24];
      default: byte_sel = mem_word[7:0];
    endcase
    half_sel = alu_result[1] ? mem_word[31:16] : mem_word[15:0];
    case (load_op)
      OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data = {24'd0, byte_sel};
      OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_data = {16'd0, half_sel};
      default: load_data = mem_word;
    endcase
  end

  assign final_result = res_from_mem ? load_data : alu_result;

  assign ms_to_ws_bus = {gr_we, dest, final_result, pc};
  assign ms_to_ds_bus = {ms_valid && gr_we, ms_valid && res_from_mem && !resp,
                         dest, final_result};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid  <= 1'b0;
      buf_valid <= 1'b0;
    end else begin
      if (ms_allowin) begin
        ms_valid <= es_to_ms_valid;
      end
      // Clearing on departure keeps the next load from seeing stale data.
      if (ms_to_ws_valid && ws_allowin) begin
        buf_valid <= 1'b0;
      end else if (buf_capture) begin
        buf_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (es_to_ms_valid && ms_allowin) begin
      ms_bus_r <= es_to_ms_bus;
    end
    if (buf_capture) begin
      rdata_buf <= data_sram_rdata;
    end
  end

endmodule
`default_nettype wire
